if_stage: RTL

- Instruction-fetch stage: owns the PC register, drives the instruction-memory address and exports PC+4 to the next-PC unit.
- Selects the next PC from four sources:
  - sequential PC+4
  - the next-PC unit's branch/jump result
  - a jr/jalr register target
  - exception entry or eret return
- Captures the fetched word into the IF/ID pipeline register with stall/flush control.
- Flags illegal fetch addresses with AdEL (ExcCode 4).

---
 rtl/mips_defs.sv | 20 ++
 rtl/pc_reg.sv | 60 ++++++
 rtl/if_stage.sv | 81 ++++++++
 3 files changed

// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: PC-select encodings, exception codes
// and default fetch addresses.
package mips_defs;

    typedef enum logic [1:0] {
        PCSEL_PC4 = 2'd0,
        PCSEL_NPC = 2'd1,
        PCSEL_JR  = 2'd2,
        PCSEL_RSV = 2'd3
    } pcsel_e;

    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] DEF_IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_LIMIT  = 32'h0000_4FFC;

endpackage

// File: rtl/pc_reg.sv
// PC register with prioritised redirect selection and fetch-address fault
// detection (misaligned or outside instruction memory).
module pc_reg
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] EXC_ENTRY = DEF_EXC_ENTRY,
    parameter logic [31:0] IM_BASE   = DEF_IM_BASE,
    parameter logic [31:0] IM_LIMIT  = DEF_IM_LIMIT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] npc_in,
    input  logic [31:0] jr_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        fault
);

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    pcsel_e      sel;

    assign sel   = pcsel_e'(pc_sel);
    assign pc    = pc_q;
    assign pc4   = pc_q + 32'd4;
    assign fault = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT);

    // Exception beats eret beats stall beats the normal source select.
    always_comb begin
        pc_next = pc4;
        if (exc_req) begin
            pc_next = EXC_ENTRY;
        end else if (eret_req) begin
            pc_next = epc;
        end else if (stall) begin
            pc_next = pc_q;
        end else begin
            case (sel)
                PCSEL_NPC: pc_next = npc_in;
                PCSEL_JR:  pc_next = jr_target;
                default:   pc_next = pc4;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register plus the IF/ID pipeline register with
// stall/flush control and AdEL tagging of faulting fetches.
module if_stage
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] EXC_ENTRY = DEF_EXC_ENTRY,
    parameter logic [31:0] IM_BASE   = DEF_IM_BASE,
    parameter logic [31:0] IM_LIMIT  = DEF_IM_LIMIT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] npc_in,
    input  logic [31:0] jr_target,
    input  logic        id_is_jump,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc4,
    output logic [4:0]  d_exccode,
    output logic        d_bd
);

    logic        fault;
    logic [31:0] fetch_word;

    pc_reg #(
        .RESET_PC  (RESET_PC),
        .EXC_ENTRY (EXC_ENTRY),
        .IM_BASE   (IM_BASE),
        .IM_LIMIT  (IM_LIMIT)
    ) u_pc_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall     (stall),
        .pc_sel    (pc_sel),
        .npc_in    (npc_in),
        .jr_target (jr_target),
        .exc_req   (exc_req),
        .eret_req  (eret_req),
        .epc       (epc),
        .pc        (pc),
        .pc4       (pc4),
        .fault     (fault)
    );

    assign im_addr    = pc;
    // A faulting fetch enters the pipe as a nop so only the AdEL tag matters.
    assign fetch_word = fault ? '0 : im_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_instr   <= '0;
            d_pc      <= '0;
            d_pc4     <= '0;
            d_exccode <= EXC_NONE;
            d_bd      <= 1'b0;
        end else if (exc_req || eret_req) begin
            d_instr   <= '0;
            d_pc      <= '0;
            d_pc4     <= '0;
            d_exccode <= EXC_NONE;
            d_bd      <= 1'b0;
        end else if (!stall) begin
            d_instr   <= fetch_word;
            d_pc      <= pc;
            d_pc4     <= pc4;
            d_exccode <= fault ? EXC_ADEL : EXC_NONE;
            d_bd      <= id_is_jump;
        end
    end

endmodule
